// File: rtl/kare_hesapla.sv
// kare_hesapla: iterative 64x64 shift-add squarer, 32.32 in, 16.16 out.
// Define YUVARLAMA_EN for round-to-nearest instead of truncation.
module kare_hesapla (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        basla,
    input  logic [63:0] sayi,
    output logic [31:0] sonuc,
    output logic        tasma,
    output logic        hazir,
    output logic        gecerli
);

    typedef enum logic [1:0] {
        BOSTA   = 2'd0,
        HESAPLA = 2'd1,
        SON     = 2'd2
    } durum_t;

    durum_t         durum_q, durum_d;
    logic [63:0]    islenen_q, islenen_d;
    logic [6:0]     sayac_q, sayac_d;
    logic [127:0]   birikim_q, birikim_d;
    logic [31:0]    sonuc_q, sonuc_d;
    logic           tasma_q, tasma_d;
    logic           gecerli_q, gecerli_d;

    logic [127:0]   kaydirilmis;
    logic [32:0]    yuvarli;
    logic           tasma_hesap;
    logic [31:0]    sonuc_hesap;

    assign kaydirilmis = {64'd0, islenen_q} << sayac_q;

    // Format the 64.64 product into saturated 16.16
    always_comb begin
`ifdef YUVARLAMA_EN
        yuvarli = {1'b0, birikim_q[79:48]} + {32'd0, birikim_q[47]};
`else
        yuvarli = {1'b0, birikim_q[79:48]};
`endif
        tasma_hesap = (|birikim_q[127:80]) | yuvarli[32];
        sonuc_hesap = tasma_hesap ? 32'hFFFF_FFFF : yuvarli[31:0];
    end

    // Next-state and datapath control
    always_comb begin
        durum_d   = durum_q;
        islenen_d = islenen_q;
        sayac_d   = sayac_q;
        birikim_d = birikim_q;
        sonuc_d   = sonuc_q;
        tasma_d   = tasma_q;
        gecerli_d = 1'b0;
        unique case (durum_q)
            BOSTA: begin
                if (basla) begin
                    islenen_d = sayi;
                    sayac_d   = 7'd0;
                    birikim_d = 128'd0;
                    durum_d   = HESAPLA;
                end
            end
            HESAPLA: begin
                if (islenen_q[sayac_q[5:0]]) begin
                    birikim_d = birikim_q + kaydirilmis;
                end
                sayac_d = sayac_q + 7'd1;
                if (sayac_q == 7'd63) begin
                    durum_d = SON;
                end
            end
            SON: begin
                sonuc_d   = sonuc_hesap;
                tasma_d   = tasma_hesap;
                gecerli_d = 1'b1;
                durum_d   = BOSTA;
            end
            default: begin
                durum_d = BOSTA;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum_q   <= BOSTA;
            islenen_q <= 64'd0;
            sayac_q   <= 7'd0;
            birikim_q <= 128'd0;
            sonuc_q   <= 32'd0;
            tasma_q   <= 1'b0;
            gecerli_q <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            islenen_q <= islenen_d;
            sayac_q   <= sayac_d;
            birikim_q <= birikim_d;
            sonuc_q   <= sonuc_d;
            tasma_q   <= tasma_d;
            gecerli_q <= gecerli_d;
        end
    end

    assign sonuc   = sonuc_q;
    assign tasma   = tasma_q;
    assign gecerli = gecerli_q;
    assign hazir   = (durum_q == BOSTA);

endmodule

// File: tb/tb_kare_hesapla.sv
// tb_kare_hesapla: directed vectors for the kare_hesapla squarer.
// Expected values follow the YUVARLAMA_EN setting of the build.
module tb_kare_hesapla;

    logic        clk;
    logic        rst_n;
    logic        basla;
    logic [63:0] sayi;
    logic [31:0] sonuc;
    logic        tasma;
    logic        hazir;
    logic        gecerli;

    int toplam = 0;
    int hatali = 0;

    kare_hesapla dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .basla   (basla),
        .sayi    (sayi),
        .sonuc   (sonuc),
        .tasma   (tasma),
        .hazir   (hazir),
        .gecerli (gecerli)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef YUVARLAMA_EN
    localparam logic [31:0] KUCUK_S  = 32'h0000_0001;
    localparam logic        TASIR_T  = 1'b1;
`else
    localparam logic [31:0] KUCUK_S  = 32'h0000_0000;
    localparam logic        TASIR_T  = 1'b0;
`endif

    task automatic kontrol(input string etiket,
                           input logic [63:0] gozlenen,
                           input logic [63:0] beklenen);
        toplam++;
        if (gozlenen !== beklenen) begin
            hatali++;
            $display("FAIL %s: gozlenen=%h beklenen=%h",
                     etiket, gozlenen, beklenen);
        end
    endtask

    task automatic islem(input string       etiket,
                         input logic [63:0] v,
                         input logic [31:0] bs,
                         input logic        bt,
                         input bit          ikinci);
        int          darbe;
        int          yer;
        logic [31:0] s;
        logic        t;
        logic        h64;
        logic        h65;
        darbe = 0;
        yer   = 0;
        s     = 32'h0;
        t     = 1'b0;
        h64   = 1'b1;
        h65   = 1'b0;
        @(negedge clk);
        basla = 1'b1;
        sayi  = v;
        kontrol({etiket, "_hazir"}, {63'd0, hazir}, 64'd1);
        @(posedge clk);
        #1;
        basla = 1'b0;
        sayi  = ~v;
        kontrol({etiket, "_mesgul"}, {63'd0, hazir}, 64'd0);
        for (int n = 1; n <= 66; n++) begin
            @(posedge clk);
            #1;
            if (gecerli) begin
                darbe++;
                yer = n;
                s   = sonuc;
                t   = tasma;
            end
            if (n == 64) h64 = hazir;
            if (n == 65) h65 = hazir;
            if (ikinci && n == 9) begin
                basla = 1'b1;
                sayi  = 64'h0000_0003_0000_0000;
            end
            if (ikinci && n == 10) begin
                basla = 1'b0;
                sayi  = ~v;
            end
        end
        kontrol({etiket, "_darbe"}, 64'(darbe), 64'd1);
        kontrol({etiket, "_yer"}, 64'(yer), 64'd65);
        kontrol({etiket, "_sonuc"}, {32'd0, s}, {32'd0, bs});
        kontrol({etiket, "_tasma"}, {63'd0, t}, {63'd0, bt});
        kontrol({etiket, "_h64"}, {63'd0, h64}, 64'd0);
        kontrol({etiket, "_h65"}, {63'd0, h65}, 64'd1);
        kontrol({etiket, "_tut"}, {32'd0, sonuc}, {32'd0, bs});
    endtask

    initial begin
        int darbe;
        int y1;
        int y2;
        logic h66;
        rst_n = 1'b0;
        basla = 1'b0;
        sayi  = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        kontrol("rst_sonuc", {32'd0, sonuc}, 64'd0);
        kontrol("rst_tasma", {63'd0, tasma}, 64'd0);
        kontrol("rst_hazir", {63'd0, hazir}, 64'd1);
        kontrol("rst_gecerli", {63'd0, gecerli}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        islem("iki", 64'h0000_0002_0000_0000, 32'h0004_0000, 1'b0, 1'b0);
        islem("birbucuk", 64'h0000_0001_8000_0000, 32'h0002_4000, 1'b0, 1'b0);
        islem("ikiyuzelli", 64'h0000_0100_0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        islem("kucuk", 64'h0000_0000_00C0_0000, KUCUK_S, 1'b0, 1'b0);
        islem("tasir", 64'h0000_00FF_FFFF_FFFF, 32'hFFFF_FFFF, TASIR_T, 1'b0);
        islem("sifir", 64'h0, 32'h0, 1'b0, 1'b0);
        islem("mesgul", 64'h0000_0002_0000_0000, 32'h0004_0000, 1'b0, 1'b1);

        // basla held high: two results 66 cycles apart
        darbe = 0;
        y1    = 0;
        y2    = 0;
        h66   = 1'b1;
        @(negedge clk);
        basla = 1'b1;
        sayi  = 64'h0000_0001_8000_0000;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 131; n++) begin
            @(posedge clk);
            #1;
            if (gecerli) begin
                darbe++;
                if (darbe == 1) y1 = n;
                if (darbe == 2) y2 = n;
            end
            if (n == 66) h66 = hazir;
        end
        basla = 1'b0;
        kontrol("ardisik_darbe", 64'(darbe), 64'd2);
        kontrol("ardisik_y1", 64'(y1), 64'd65);
        kontrol("ardisik_y2", 64'(y2), 64'd131);
        kontrol("ardisik_h66", {63'd0, h66}, 64'd0);
        kontrol("ardisik_sonuc", {32'd0, sonuc}, 64'h0002_4000);
        repeat (3) @(posedge clk);

        // reset in the middle of an operation
        @(negedge clk);
        basla = 1'b1;
        sayi  = 64'h0000_0002_0000_0000;
        @(posedge clk);
        #1;
        basla = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        kontrol("iptal_sonuc", {32'd0, sonuc}, 64'd0);
        kontrol("iptal_tasma", {63'd0, tasma}, 64'd0);
        kontrol("iptal_hazir", {63'd0, hazir}, 64'd1);
        kontrol("iptal_gecerli", {63'd0, gecerli}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        darbe = 0;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            #1;
            if (gecerli) darbe++;
        end
        kontrol("iptal_darbe", 64'(darbe), 64'd0);
        kontrol("iptal_bosta", {63'd0, hazir}, 64'd1);

        islem("sonra", 64'h0000_0001_8000_0000, 32'h0002_4000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", toplam, hatali);
        $finish;
    end

endmodule
